// File: rtl/iencoder_if.sv
// Encoding constants and the request/response bundle for the RV32I instruction encoder.
// Slave modport faces the encoder; master faces whoever produces and consumes words.
package iencoder_pkg;

    localparam int INST_TYPE_WIDTH = 3;
    localparam int IMM_WIDTH       = 32;
    localparam int REG_WIDTH       = 5;
    localparam int FUNCT_WIDTH     = 3;
    localparam int INST_WIDTH      = 32;

    typedef enum logic [INST_TYPE_WIDTH-1:0] {
        INST_TYPE_IMM     = 3'd0,
        INST_TYPE_JAL     = 3'd1,
        INST_TYPE_INT_IMM = 3'd2,
        INST_TYPE_INT_REG = 3'd3,
        INST_TYPE_BRANCH  = 3'd4,
        INST_TYPE_STORE   = 3'd5
    } inst_type_e;

    typedef enum logic [FUNCT_WIDTH-1:0] {
        FUNCT_ADD       = 3'd0,
        FUNCT_SUB       = 3'd1,
        FUNCT_EQ        = 3'd2,
        FUNCT_MEM_WORD  = 3'd3,
        FUNCT_MEM_HWORD = 3'd4,
        FUNCT_MEM_BYTE  = 3'd5
    } funct_e;

endpackage

interface iencoder_if;
    import iencoder_pkg::*;

    logic                       in_valid;
    logic                       in_ready;
    logic [INST_TYPE_WIDTH-1:0] inst_type;
    logic [IMM_WIDTH-1:0]       imm;
    logic [REG_WIDTH-1:0]       rd;
    logic [REG_WIDTH-1:0]       rs1;
    logic [REG_WIDTH-1:0]       rs2;
    logic [FUNCT_WIDTH-1:0]     funct;
    logic                       out_valid;
    logic                       out_ready;
    logic [INST_WIDTH-1:0]      inst;
    logic [15:0]                inst_count;
    logic                       err_unsup;
    logic                       err_range;

    modport slave (
        input  in_valid, inst_type, imm, rd, rs1, rs2, funct, out_ready,
        output in_ready, out_valid, inst, inst_count, err_unsup, err_range
    );

    modport master (
        output in_valid, inst_type, imm, rd, rs1, rs2, funct, out_ready,
        input  in_ready, out_valid, inst, inst_count, err_unsup, err_range
    );

endinterface

// File: rtl/iencoder.sv
// RV32I field-bundle encoder feeding a 2-entry output FIFO, with sticky error flags.
// Define IENCODER_RANGE_CHECK_EN to drop unencodable immediates instead of truncating them.
module iencoder
    import iencoder_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    iencoder_if.slave  bus
);

    logic [INST_WIDTH-1:0] enc_word;
    logic                  enc_ok;
    logic [2:0]            f3;
    logic [6:0]            f7;
    logic                  range_drop;

    logic                  accept;
    logic                  push;
    logic                  pop;

    logic [INST_WIDTH-1:0] mem_q [2];
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            count_q, count_d;
    logic [15:0]           inst_count_q, inst_count_d;
    logic                  err_unsup_q, err_unsup_d;
    logic                  err_range_q, err_range_d;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        f3 = 3'b000;
        f7 = 7'b0000000;
        case (bus.funct)
            FUNCT_SUB:       f7 = 7'b0100000;
            FUNCT_MEM_WORD:  f3 = 3'b010;
            FUNCT_MEM_HWORD: f3 = 3'b001;
            default:         f3 = 3'b000;
        endcase
    end

    always_comb begin
        enc_ok   = 1'b0;
        enc_word = '0;
        case (bus.inst_type)
            INST_TYPE_IMM: begin
                enc_ok   = 1'b1;
                enc_word = {bus.imm[31:12], bus.rd, 7'b0110111};
            end
            INST_TYPE_JAL: begin
                enc_ok   = 1'b1;
                enc_word = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                            bus.rd, 7'b1101111};
            end
            INST_TYPE_INT_IMM: begin
                enc_ok   = (bus.funct == FUNCT_ADD);
                enc_word = {bus.imm[11:0], bus.rs1, f3, bus.rd, 7'b0010011};
            end
            INST_TYPE_INT_REG: begin
                enc_ok   = (bus.funct == FUNCT_ADD) || (bus.funct == FUNCT_SUB);
                enc_word = {f7, bus.rs2, bus.rs1, f3, bus.rd, 7'b0110011};
            end
            INST_TYPE_BRANCH: begin
                enc_ok   = (bus.funct == FUNCT_EQ);
                enc_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, f3,
                            bus.imm[4:1], bus.imm[11], 7'b1100011};
            end
            INST_TYPE_STORE: begin
                enc_ok   = (bus.funct == FUNCT_MEM_WORD) || (bus.funct == FUNCT_MEM_HWORD) ||
                           (bus.funct == FUNCT_MEM_BYTE);
                enc_word = {bus.imm[11:5], bus.rs2, bus.rs1, f3, bus.imm[4:0], 7'b0100011};
            end
            default: begin
                enc_ok   = 1'b0;
                enc_word = '0;
            end
        endcase
    end

`ifdef IENCODER_RANGE_CHECK_EN
    logic range_bad;

    // Immediate must be exactly representable by the bits the format keeps.
    always_comb begin
        range_bad = 1'b0;
        case (bus.inst_type)
            INST_TYPE_IMM:
                range_bad = (bus.imm[11:0] != 12'h000);
            INST_TYPE_JAL:
                range_bad = (bus.imm != {{11{bus.imm[20]}}, bus.imm[20:0]}) || bus.imm[0];
            INST_TYPE_INT_IMM, INST_TYPE_STORE:
                range_bad = (bus.imm != {{20{bus.imm[11]}}, bus.imm[11:0]});
            INST_TYPE_BRANCH:
                range_bad = (bus.imm != {{19{bus.imm[12]}}, bus.imm[12:0]}) || bus.imm[0];
            default:
                range_bad = 1'b0;
        endcase
    end

    assign range_drop = enc_ok && range_bad;
`else
    assign range_drop = 1'b0;
`endif

    // No pass-through: a full FIFO refuses input even when it is being drained.
    assign bus.in_ready  = !rst && (count_q != 2'd2);
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.inst      = bus.out_valid ? mem_q[rd_ptr_q] : '0;

    assign accept = bus.in_valid && bus.in_ready;
    assign push   = accept && enc_ok && !range_drop;
    assign pop    = bus.out_valid && bus.out_ready;

    always_comb begin
        wr_ptr_d     = wr_ptr_q ^ push;
        rd_ptr_d     = rd_ptr_q ^ pop;
        count_d      = count_q;
        inst_count_d = inst_count_q + {15'd0, pop};
        err_unsup_d  = err_unsup_q | (accept && !enc_ok);
        err_range_d  = err_range_q | (accept && range_drop);
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= 2'd0;
            inst_count_q <= 16'd0;
            err_unsup_q  <= 1'b0;
            err_range_q  <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            inst_count_q <= inst_count_d;
            err_unsup_q  <= err_unsup_d;
            err_range_q  <= err_range_d;
        end
    end

    // NOTE: storage is deliberately not reset; stale entries are unreachable because inst is masked while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= enc_word;
        end
    end

    assign bus.inst_count = inst_count_q;
    assign bus.err_unsup  = err_unsup_q;
    assign bus.err_range  = err_range_q;

endmodule

// File: tb/tb_iencoder.sv
// Scoreboard bench for iencoder: expected words are queued on accept and compared on delivery.
// Build with IENCODER_RANGE_CHECK_EN defined to exercise the range-checking variant.
module tb_iencoder;
    import iencoder_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    iencoder_if bus ();

    iencoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q [$];
    int          exp_count = 0;
    bit          exp_unsup = 1'b0;
    bit          exp_range = 1'b0;
    bit          mon_en    = 1'b0;

    bit          drv_push;
    logic [31:0] drv_word;
    bit          drv_unsup;
    bit          drv_range;
    int          last_wait;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Model of FIFO content, delivered-word count and sticky flags, updated on the same edges as the DUT.
    always @(negedge clk) begin
        if (mon_en) begin
            check("inst_count", {16'h0, bus.inst_count}, 32'(exp_count & 16'hFFFF));
            check("err_unsup", {31'h0, bus.err_unsup}, {31'h0, exp_unsup});
            check("err_range", {31'h0, bus.err_range}, {31'h0, exp_range});
            check("out_valid", {31'h0, bus.out_valid}, {31'h0, exp_q.size() != 0});
            if (rst) begin
                exp_q.delete();
                exp_count = 0;
                exp_unsup = 1'b0;
                exp_range = 1'b0;
            end else begin
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("scoreboard_size", 32'(exp_q.size()), 32'd1);
                    end else begin
                        check("inst", bus.inst, exp_q.pop_front());
                    end
                    exp_count++;
                end
                if (bus.in_valid && bus.in_ready) begin
                    if (drv_push) exp_q.push_back(drv_word);
                    exp_unsup |= drv_unsup;
                    exp_range |= drv_range;
                end
            end
        end
    end

    // Entered and left at posedge+1 time unit.
    task automatic send(input logic [2:0] t, input logic [2:0] f, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                        input bit push, input logic [31:0] word, input bit unsup, input bit rng);
        bit accepted;
        bus.inst_type = t;
        bus.funct     = f;
        bus.rd        = rd;
        bus.rs1       = rs1;
        bus.rs2       = rs2;
        bus.imm       = imm;
        drv_push      = push;
        drv_word      = word;
        drv_unsup     = unsup;
        drv_range     = rng;
        bus.in_valid  = 1'b1;
        last_wait     = 0;
        accepted      = 1'b0;
        for (int i = 0; i < 40 && !accepted; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                accepted = 1'b1;
            end else begin
                last_wait++;
                @(posedge clk);
                #1;
            end
        end
        check("accepted", {31'h0, accepted}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic stream_send(input logic [2:0] t, input logic [2:0] f, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                               input logic [31:0] word);
        send(t, f, rd, rs1, rs2, imm, 1'b1, word, 1'b0, 1'b0);
        check("stream_wait", 32'(last_wait), 32'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit acc;
        bit rc;
`ifdef IENCODER_RANGE_CHECK_EN
        rc = 1'b1;
`else
        rc = 1'b0;
`endif
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.inst_type = '0;
        bus.funct     = '0;
        bus.imm       = '0;
        bus.rd        = '0;
        bus.rs1       = '0;
        bus.rs2       = '0;
        drv_push      = 1'b0;
        drv_word      = '0;
        drv_unsup     = 1'b0;
        drv_range     = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("in_ready_in_rst", {31'h0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {31'h0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
        check("rst_inst", bus.inst, 32'h0);
        check("rst_inst_count", {16'h0, bus.inst_count}, 32'h0);
        @(posedge clk);
        #1;

        // First word: valid exactly one cycle after accept.
        send(INST_TYPE_INT_IMM, FUNCT_ADD, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h00500093, 1'b0, 1'b0);
        @(negedge clk);
        check("latency_out_valid", {31'h0, bus.out_valid}, 32'd1);
        check("latency_inst", bus.inst, 32'h00500093);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        drain();

        // Back-to-back stream with a ready consumer: occupancy never exceeds one.
        stream_send(INST_TYPE_INT_REG, FUNCT_SUB,       5'd3,  5'd1,  5'd2,  32'd0,        32'h402081B3);
        stream_send(INST_TYPE_IMM,     FUNCT_ADD,       5'd5,  5'd0,  5'd0,  32'h12345000, 32'h123452B7);
        stream_send(INST_TYPE_STORE,   FUNCT_MEM_WORD,  5'd0,  5'd1,  5'd2,  32'd8,        32'h0020A423);
        stream_send(INST_TYPE_BRANCH,  FUNCT_EQ,        5'd0,  5'd1,  5'd2,  32'hFFFFFFFC, 32'hFE208EE3);
        stream_send(INST_TYPE_JAL,     FUNCT_ADD,       5'd1,  5'd0,  5'd0,  32'h00000800, 32'h001000EF);
        stream_send(INST_TYPE_INT_REG, FUNCT_ADD,       5'd10, 5'd11, 5'd12, 32'd0,        32'h00C58533);
        stream_send(INST_TYPE_STORE,   FUNCT_MEM_HWORD, 5'd0,  5'd2,  5'd3,  32'hFFFFFFFE, 32'hFE311F23);
        stream_send(INST_TYPE_STORE,   FUNCT_MEM_BYTE,  5'd0,  5'd5,  5'd6,  32'd0,        32'h00628023);
        stream_send(INST_TYPE_INT_IMM, FUNCT_ADD,       5'd0,  5'd0,  5'd0,  32'hFFFFF800, 32'h80000013);
        stream_send(INST_TYPE_INT_IMM, FUNCT_ADD,       5'd0,  5'd0,  5'd0,  32'h000007FF, 32'h7FF00013);
        drain();

        // Unsupported combinations are swallowed and flagged.
        send(INST_TYPE_INT_REG, FUNCT_EQ,  5'd1, 5'd1, 5'd1, 32'd0, 1'b0, 32'h0, 1'b1, 1'b0);
        send(3'd6,              FUNCT_ADD, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, 32'h0, 1'b1, 1'b0);
        send(INST_TYPE_INT_IMM, FUNCT_SUB, 5'd1, 5'd1, 5'd1, 32'd1, 1'b0, 32'h0, 1'b1, 1'b0);

        // Out-of-range immediates: dropped with the check, truncated without it.
        send(INST_TYPE_INT_IMM, FUNCT_ADD, 5'd0, 5'd0, 5'd0, 32'h00000800, !rc, 32'h80000013, 1'b0, rc);
        send(INST_TYPE_IMM,     FUNCT_ADD, 5'd0, 5'd0, 5'd0, 32'h12345001, !rc, 32'h12345037, 1'b0, rc);
        send(INST_TYPE_BRANCH,  FUNCT_EQ,  5'd0, 5'd1, 5'd2, 32'h00000005, !rc, 32'h00208263, 1'b0, rc);
        drain();

        // Backpressure: two accepts fill the FIFO, the third waits, head holds steady.
        bus.out_ready = 1'b0;
        send(INST_TYPE_INT_REG, FUNCT_SUB, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h402081B3, 1'b0, 1'b0);
        send(INST_TYPE_IMM,     FUNCT_ADD, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b1, 32'h123452B7, 1'b0, 1'b0);
        bus.inst_type = INST_TYPE_JAL;
        bus.funct     = FUNCT_ADD;
        bus.rd        = 5'd1;
        bus.imm       = 32'h00000800;
        drv_push      = 1'b1;
        drv_word      = 32'h001000EF;
        drv_unsup     = 1'b0;
        drv_range     = 1'b0;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_in_ready", {31'h0, bus.in_ready}, 32'd0);
            check("held_inst", bus.inst, 32'h402081B3);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("no_passthrough", {31'h0, bus.in_ready}, 32'd0);
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (bus.in_ready) acc = 1'b1;
        end
        check("third_accepted", {31'h0, acc}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        drain();

        // Reset while full discards buffered words, the count and the flags.
        bus.out_ready = 1'b0;
        send(INST_TYPE_INT_IMM, FUNCT_ADD, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h00500093, 1'b0, 1'b0);
        send(INST_TYPE_INT_IMM, FUNCT_ADD, 5'd2, 5'd0, 5'd0, 32'd6, 1'b1, 32'h00600113, 1'b0, 1'b0);
        @(negedge clk);
        check("pre_rst_full", {31'h0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_pulse_in_ready", {31'h0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_out_valid", {31'h0, bus.out_valid}, 32'd0);
        check("post_rst_in_ready", {31'h0, bus.in_ready}, 32'd1);
        check("post_rst_inst", bus.inst, 32'h0);
        check("post_rst_count", {16'h0, bus.inst_count}, 32'h0);
        check("post_rst_unsup", {31'h0, bus.err_unsup}, 32'd0);
        check("post_rst_range", {31'h0, bus.err_range}, 32'd0);
        @(posedge clk);
        #1;

        bus.out_ready = 1'b1;
        send(INST_TYPE_STORE, FUNCT_MEM_WORD, 5'd0, 5'd1, 5'd2, 32'd8, 1'b1, 32'h0020A423, 1'b0, 1'b0);
        drain();
        @(negedge clk);
        check("final_count", {16'h0, bus.inst_count}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iencoder.md
IENCODER -- requirements
Module: iencoder

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have ports: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: in_valid  input  1  request holds a field bundle to encode.
REQ-004 SHALL have ports: in_ready  output  1  encoder accepts bundle this cycle.
REQ-005 SHALL have ports: inst_type  input  INST_TYPE_WIDTH  INST_TYPE_IMM/JAL/INT_IMM/INT_REG/BRANCH/STORE.
REQ-006 SHALL have ports: imm  input  IMM_WIDTH  architectural immediate value, not yet scrambled.
REQ-007 SHALL have ports: rd, rs1, rs2  input  REG_WIDTH each  register indices.
REQ-008 SHALL have ports: funct  input  FUNCT_WIDTH  FUNCT_ADD/SUB/EQ/MEM_WORD/MEM_HWORD/MEM_BYTE.
REQ-009 SHALL have ports: out_valid  output  1  inst holds an encoded word.
REQ-010 SHALL have ports: out_ready  input  1  consumer takes inst this cycle.
REQ-011 SHALL have ports: inst  output  INST_WIDTH  encoded RV32I word.
REQ-012 SHALL have ports: inst_count  output  16  number of words delivered, wraps 0xFFFF->0x0000.
REQ-013 SHALL have ports: err_unsup  output  1  sticky flag: unsupported type/funct dropped.
REQ-014 SHALL have ports: err_range  output  1  sticky flag: unencodable immediate dropped.

Function
REQ-015 SHALL accept a bundle on a cycle with in_valid && in_ready, and produce no other side effects.
REQ-016 SHALL encode: IMM (LUI) -> {imm[31:12], rd, 0110111}; JAL -> {imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111}.
REQ-017 SHALL encode: INT_IMM -> {imm[11:0], rs1, f3, rd, 0010011}; INT_REG -> {f7, rs2, rs1, f3, rd, 0110011}.
REQ-018 SHALL encode: BRANCH -> {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 1100011}; STORE -> {imm[11:5], rs2, rs1, f3, imm[4:0], 0100011}.
REQ-019 SHALL map funct: ADD f7=0 f3=000; SUB f7=0100000 f3=000 (INT_REG only); EQ f3=000; MEM_WORD 010, MEM_HWORD 001, MEM_BYTE 000.
REQ-020 SHALL treat any other type/funct combination as unsupported: accept it, write nothing, set err_unsup.
REQ-021 SHALL buffer encoded words in a 2-entry FIFO; in_ready = FIFO not full; out_valid = FIFO not empty; inst = head entry.
REQ-022 SHALL assert out_valid the cycle after accept when the FIFO was empty; no combinational in->out path.
REQ-023 SHALL, with one entry, push and pop in the same cycle, leaving occupancy at 1 and preserving order.
REQ-024 SHALL keep in_ready low when full, even if out_ready is high that cycle (no pass-through).
REQ-025 SHALL hold inst stable while out_valid && !out_ready.
REQ-026 SHALL increment inst_count on every out_valid && out_ready cycle.
REQ-027 SHALL keep err_unsup/err_range set until rst.

Reset
REQ-028 SHALL, on rst high at a clock edge, empty the FIFO and clear inst_count, err_unsup and err_range. Buffered words are discarded.
REQ-029 SHALL drive in_ready=0 while rst is high, and in_ready=1 on the first cycle after rst is released. Outputs after reset: out_valid=0, inst=0.

Configuration
REQ-030 SHALL, with IENCODER_RANGE_CHECK_EN defined, drop the bundle and set err_range for any of these immediates:
- LUI with imm[11:0]!=0;
- INT_IMM or STORE with imm not the sign-extension of its low 12 bits;
- BRANCH with imm not the sign-extension of its low 13 bits, or imm[0]!=0;
- JAL with imm not the sign-extension of its low 21 bits, or imm[0]!=0.
REQ-031 SHALL, without IENCODER_RANGE_CHECK_EN, silently truncate out-of-range immediates and tie err_range to 0.

Verification
REQ-032 SHALL cover: INT_IMM ADD rd=1 rs1=0 imm=5 -> inst=0x00500093; INT_REG SUB rd=3 rs1=1 rs2=2 -> 0x402081B3.
REQ-033 SHALL cover: IMM rd=5 imm=0x12345000 -> 0x123452B7; STORE WORD rs1=1 rs2=2 imm=8 -> 0x0020A423.
REQ-034 SHALL cover: BRANCH EQ rs1=1 rs2=2 imm=-4 -> 0xFE208EE3; JAL rd=1 imm=0x800 -> 0x001000EF.
REQ-035 SHALL cover backpressure: out_ready=0, three back-to-back bundles -> in_ready low after two accepts, inst stable. Release -> words in order, inst_count=2, then 3.
REQ-036 SHALL cover errors: INT_REG with funct=EQ -> no output, err_unsup=1. With the macro defined, INT_IMM imm=0x800 -> no output, err_range=1. Without it, the same bundle -> 0x80000013.
REQ-037 SHALL cover reset mid-operation: FIFO full, rst pulsed one cycle -> out_valid=0, inst_count=0, flags 0, in_ready=1 next cycle.
